// File: rtl/ether_rx.sv
// rtl/ether_rx.sv - byte-serial Ethernet frame receiver: preamble/SFD hunt, field capture, frame_valid pulse.
// Optional length check against DATA_BYTES is enabled with `define ETHER_RX_LEN_CHECK_EN.
module ether_rx #(
    parameter int          PRE_BYTES  = 7,
    parameter logic [7:0]  SFD_BYTE   = 8'hAB,
    parameter int          DATA_BYTES = 46
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                din,
    input  logic                      din_valid,
    output logic [47:0]               da,
    output logic [47:0]               sa,
    output logic [15:0]               len,
    output logic [8*DATA_BYTES-1:0]   data,
    output logic [31:0]               crc,
    output logic                      frame_valid,
    output logic                      busy,
    output logic                      err
);
    localparam int TOT = 18 + DATA_BYTES;
    localparam int SHW = (TOT - 1) * 8;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int CW  = $clog2(DATA_BYTES > 6 ? DATA_BYTES : 6);
    localparam int PW  = $clog2(PRE_BYTES + 1);

    typedef enum logic [2:0] {S_HUNT, S_SFD, S_DA, S_SA, S_LEN, S_DATA, S_CRC} state_t;

    state_t            state, next_state;
    logic [PW-1:0]     pcnt;
    logic [CW-1:0]     bcnt;
    logic [CW-1:0]     field_max;
    logic [SHW-1:0]    shadow;
    logic [TOT*8-1:0]  frame_bits;
    logic              field_last, in_field, shift_en;
    logic              sfd_hit, sfd_bad, frame_done, len_ok;
    logic              pre_last;

`ifdef ETHER_RX_LEN_CHECK_EN
    logic              len_bad;
    logic              len_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_HUNT;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (din_valid) begin
            case (state)
                S_HUNT: if (din == 8'hAA && pre_last) next_state = S_SFD;
                S_SFD: begin
                    if (din == SFD_BYTE)     next_state = S_DA;
                    else if (din != 8'hAA)   next_state = S_HUNT;
                end
                S_DA:   if (field_last) next_state = S_SA;
                S_SA:   if (field_last) next_state = S_LEN;
                S_LEN:  if (field_last) next_state = S_DATA;
                S_DATA: if (field_last) next_state = S_CRC;
                S_CRC:  if (field_last) next_state = S_HUNT;
                default: next_state = S_HUNT;
            endcase
        end
    end

    always_comb begin
        field_max = '0;
        case (state)
            S_DA, S_SA: field_max = CW'(5);
            S_LEN:      field_max = CW'(1);
            S_DATA:     field_max = CW'(DATA_BYTES - 1);
            S_CRC:      field_max = CW'(3);
            default:    field_max = '0;
        endcase
        field_last = (bcnt == field_max);
        in_field   = (state == S_DA) || (state == S_SA) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CRC);
        shift_en   = din_valid && in_field;
        pre_last   = (pcnt == PW'(PRE_BYTES - 1));
        sfd_hit    = din_valid && (state == S_SFD) && (din == SFD_BYTE);
        sfd_bad    = din_valid && (state == S_SFD) && (din != SFD_BYTE) && (din != 8'hAA);
        frame_done = din_valid && (state == S_CRC) && field_last;
        frame_bits = {shadow, din};
`ifdef ETHER_RX_LEN_CHECK_EN
        len_last   = din_valid && (state == S_LEN) && field_last;
        len_ok     = !len_bad;
`else
        len_ok     = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt        <= '0;
            bcnt        <= '0;
            shadow      <= '0;
            da          <= '0;
            sa          <= '0;
            len         <= '0;
            data        <= '0;
            crc         <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
`ifdef ETHER_RX_LEN_CHECK_EN
            len_bad     <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            err         <= sfd_bad;
            if (din_valid && state == S_HUNT) begin
                if (din != 8'hAA)                     pcnt <= '0;
                else if (pcnt != PW'(PRE_BYTES))      pcnt <= pcnt + 1'b1;
            end
            if (sfd_bad || sfd_hit || frame_done) pcnt <= '0;
            if (next_state != state) bcnt <= '0;
            else if (shift_en)       bcnt <= bcnt + 1'b1;
            if (shift_en) shadow <= {shadow[SHW-9:0], din};
            if (sfd_hit)    busy <= 1'b1;
            if (frame_done) busy <= 1'b0;
`ifdef ETHER_RX_LEN_CHECK_EN
            if (len_last) len_bad <= ({shadow[7:0], din} != 16'(DATA_BYTES));
`endif
            // Fields load only from a complete frame, so a partial frame is never visible.
            if (frame_done) begin
                if (len_ok) begin
                    da          <= frame_bits[TOT*8-1 -: 48];
                    sa          <= frame_bits[TOT*8-49 -: 48];
                    len         <= frame_bits[TOT*8-97 -: 16];
                    data        <= frame_bits[32 +: DW];
                    crc         <= frame_bits[31:0];
                    frame_valid <= 1'b1;
                end else begin
                    err         <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ether_rx.sv
// tb/tb_ether_rx.sv - scoreboard bench for ether_rx with directed frames.
module tb_ether_rx;
    localparam int DB = 46;
    localparam int DW = 8 * DB;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    din;
    logic          din_valid;
    logic [47:0]   da, sa;
    logic [15:0]   len;
    logic [DW-1:0] data;
    logic [31:0]   crc;
    logic          frame_valid, busy, err;

    ether_rx #(.PRE_BYTES(7), .SFD_BYTE(8'hAB), .DATA_BYTES(DB)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .da(da), .sa(sa), .len(len), .data(data), .crc(crc),
        .frame_valid(frame_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [47:0]   da, sa;
        logic [15:0]   len;
        logic [DW-1:0] data;
        logic [31:0]   crc;
        int            cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_good;
    logic [7:0] fb[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (frame_valid || err)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: got fv=%0b err=%0b expected none at cyc %0d", frame_valid, err, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("kind", 512'({frame_valid, err}), 512'(e.is_err ? 2'b01 : 2'b10));
                chk("cycle", 512'(cyc), 512'(e.cyc));
                chk("hdr_crc", 512'({da, sa, len, crc}), 512'({e.da, e.sa, e.len, e.crc}));
                chk("data", 512'(data), 512'(e.data));
            end
        end
    end

    task automatic make_frame(input int npre, input logic [47:0] fda, input logic [47:0] fsa,
                              input logic [15:0] flen, input logic [31:0] fcrc,
                              input logic [7:0] pbase, output exp_t e);
        logic [7:0] b;
        fb.delete();
        for (int i = 0; i < npre; i++) fb.push_back(8'hAA);
        fb.push_back(8'hAB);
        for (int i = 5; i >= 0; i--) fb.push_back(fda[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(fsa[i*8 +: 8]);
        fb.push_back(flen[15:8]);
        fb.push_back(flen[7:0]);
        e.data = '0;
        for (int i = 0; i < DB; i++) begin
            b = pbase + 8'(i);
            fb.push_back(b);
            e.data = {e.data[DW-9:0], b};
        end
        for (int i = 3; i >= 0; i--) fb.push_back(fcrc[i*8 +: 8]);
        e.is_err = 1'b0;
        e.da = fda;
        e.sa = fsa;
        e.len = flen;
        e.crc = fcrc;
        e.cyc = 0;
    endtask

    task automatic send_fb(input int n, input bit stall, input int busy_at);
        for (int i = 0; i < n; i++) begin
            din = fb[i];
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i == busy_at) chk("busy_in_frame", 512'(busy), 512'(1));
            if (stall && ((i + 1) % 5 == 0) && (i + 1 < n)) begin
                din_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic good_frame(input int npre, input logic [47:0] fda, input logic [47:0] fsa,
                              input logic [15:0] flen, input logic [31:0] fcrc,
                              input logic [7:0] pbase, input bit stall);
        exp_t e;
        int   n;
        make_frame(npre, fda, fsa, flen, fcrc, pbase, e);
        n = fb.size();
        e.cyc = cyc + n + (stall ? ((n - 1) / 5) * 3 : 0);
        exp_q.push_back(e);
        last_good = e;
        send_fb(n, stall, npre);
        chk("busy_after_frame", 512'(busy), 512'(0));
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        din = 8'h00;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_hdr", 512'({da, sa, len, crc}), 512'(0));
        chk("rst_data", 512'(data), 512'(0));
        chk("rst_flags", 512'({frame_valid, busy, err}), 512'(0));

        // Test 1: clean frame
        good_frame(7, 48'h0123456789AB, 48'hA1B2C3D4E5F6, 16'h002E, 32'hDEADBEEF, 8'h00, 1'b0);
        idle(2);
        chk("data_first_byte", 512'(data[367:360]), 512'(8'h00));
        chk("data_last_byte", 512'(data[7:0]), 512'(8'h2D));
        chk("fv_single_pulse", 512'(frame_valid), 512'(0));

        // Test 2: same frame with stalls
        good_frame(7, 48'h0123456789AB, 48'hA1B2C3D4E5F6, 16'h002E, 32'hDEADBEEF, 8'h00, 1'b1);
        idle(2);

        // Test 3: bad SFD then good frame
        fb.delete();
        for (int i = 0; i < 7; i++) fb.push_back(8'hAA);
        fb.push_back(8'h55);
        e = last_good;
        e.is_err = 1'b1;
        e.cyc = cyc + 8;
        exp_q.push_back(e);
        send_fb(8, 1'b0, -1);
        idle(2);
        chk("hold_after_err", 512'(da), 512'(48'h0123456789AB));
        good_frame(7, 48'h111122223333, 48'h444455556666, 16'h002E, 32'h12345678, 8'h80, 1'b0);
        idle(2);

        // Test 4: short preamble, then extra preamble
        fb.delete();
        for (int i = 0; i < 5; i++) fb.push_back(8'hAA);
        fb.push_back(8'hAB);
        send_fb(6, 1'b0, -1);
        chk("short_pre_busy", 512'(busy), 512'(0));
        idle(3);
        good_frame(9, 48'hCAFEBABE0001, 48'h00000000FFFF, 16'h002E, 32'h0BADF00D, 8'h10, 1'b0);
        idle(2);

        // Test 5: reset during payload byte 20
        make_frame(7, 48'h999999999999, 48'h888888888888, 16'h002E, 32'h77777777, 8'h40, e);
        send_fb(8 + 14 + 20, 1'b0, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_hdr", 512'({da, sa, len, crc}), 512'(0));
        chk("midrst_data", 512'(data), 512'(0));
        chk("midrst_flags", 512'({frame_valid, busy, err}), 512'(0));
        idle(3);
        good_frame(7, 48'h0A0B0C0D0E0F, 48'h102030405060, 16'h002E, 32'hFEEDFACE, 8'h20, 1'b0);
        idle(2);

        // Test 6: length field disagrees with DATA_BYTES
`ifdef ETHER_RX_LEN_CHECK_EN
        begin
            exp_t prev;
            prev = last_good;
            make_frame(7, 48'h313131313131, 48'h424242424242, 16'h0040, 32'h55AA55AA, 8'h60, e);
            prev.is_err = 1'b1;
            prev.cyc = cyc + fb.size();
            exp_q.push_back(prev);
            send_fb(fb.size(), 1'b0, 7);
            idle(2);
            chk("lencheck_hold", 512'(len), 512'(16'h002E));
        end
`else
        good_frame(7, 48'h313131313131, 48'h424242424242, 16'h0040, 32'h55AA55AA, 8'h60, 1'b0);
        idle(2);
        chk("len_unchecked", 512'(len), 512'(16'h0040));
`endif

        idle(5);
        chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
